// File: rtl/mem_burst_pkg.sv
// Shared definitions for the burst memory sequencer.
//   state_t : FSM state encoding (IDLE, WR_DATA, WR_MEM, RD_MEM, RD_OUT, DONE)
//   DIR_WR / DIR_RD : burst direction encoding as seen on cmd_wr_i
package mem_burst_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t WR_DATA = 3'd1;
  localparam state_t WR_MEM  = 3'd2;
  localparam state_t RD_MEM  = 3'd3;
  localparam state_t RD_OUT  = 3'd4;
  localparam state_t DONE    = 3'd5;

  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

endpackage

// File: rtl/mem_burst_master.sv
// Burst access sequencer in front of a single-port memory.
// Accepts one command (start address, word count, direction), then issues one
// memory request per word, wrapping the address modulo DEPTH. Write words come
// from a valid/ready input stream, read words leave on a valid/ready output
// stream. done_o pulses for one cycle at the end of every burst.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-low reset
//   cmd_*                        burst command stream (valid/ready)
//   wr_valid_i/wr_ready_o/wr_data_i  write word stream
//   rd_valid_o/rd_ready_i/rd_data_o  read word stream
//   valid_o/wr_rd_en_o/addr_o/wdata_o/rdata_i/ready_i  memory port
//   busy_o                       high whenever not idle
//   done_o                       one-cycle burst-complete pulse
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  valid_o,
  output logic                  wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic [WIDTH-1:0]      rdata_i,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   RemOne   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   RemZero  = '0;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  dir_q, dir_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_inc;

  // Explicit wrap so non-power-of-two depths also stay in range.
  assign addr_inc = (addr_q == AddrLast) ? '0 : addr_q + AddrOne;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d = cmd_addr_i;
          rem_d  = cmd_len_i;
          dir_d  = cmd_wr_i;
          if (cmd_len_i == RemZero) begin
            state_d = DONE;
          end else if (cmd_wr_i == DIR_WR) begin
            state_d = WR_DATA;
          end else begin
            state_d = RD_MEM;
          end
        end
      end
      WR_DATA: begin
        if (wr_valid_i) begin
          wdata_d = wr_data_i;
          state_d = WR_MEM;
        end
      end
      WR_MEM: begin
        if (ready_i) begin
          addr_d  = addr_inc;
          rem_d   = rem_q - RemOne;
          state_d = (rem_q == RemOne) ? DONE : WR_DATA;
        end
      end
      RD_MEM: begin
        if (ready_i) begin
          rdata_d = rdata_i;
          addr_d  = addr_inc;
          rem_d   = rem_q - RemOne;
          state_d = RD_OUT;
        end
      end
      RD_OUT: begin
        // remaining was already decremented on the memory handshake
        if (rd_ready_i) begin
          state_d = (rem_q == RemZero) ? DONE : RD_MEM;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      dir_q   <= DIR_RD;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign wr_ready_o  = (state_q == WR_DATA);
  assign valid_o     = (state_q == WR_MEM) || (state_q == RD_MEM);
  assign wr_rd_en_o  = (state_q == WR_MEM);
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign rd_valid_o  = (state_q == RD_OUT);
  assign rd_data_o   = rdata_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_mem_burst_master.sv
module tb_mem_burst_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_wr_i;
  logic [4:0]  cmd_addr_i;
  logic [5:0]  cmd_len_i;
  logic        wr_valid_i, wr_ready_o;
  logic [15:0] wr_data_i;
  logic        rd_valid_o, rd_ready_i;
  logic [15:0] rd_data_o;
  logic        valid_o, wr_rd_en_o;
  logic [4:0]  addr_o;
  logic [15:0] wdata_o, rdata_i;
  logic        ready_i, busy_o, done_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  mem_burst_master #(.WIDTH(16), .DEPTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .valid_o(valid_o), .wr_rd_en_o(wr_rd_en_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rdata_i(rdata_i), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  // Behavioural single-port memory with programmable wait states and sink.
  logic [15:0] mem [32];
  int stall_n = 0, wcnt = 0;
  int rd_stall_n = 0, rcnt = 0;
  assign rdata_i    = mem[addr_o];
  assign ready_i    = valid_o && (wcnt >= stall_n);
  assign rd_ready_i = rd_valid_o && (rcnt >= rd_stall_n);

  // Monitor: logs memory handshakes, read-stream transfers and stability.
  logic [4:0]  mh_addr [$];
  logic [15:0] mh_data [$];
  logic        mh_we   [$];
  logic [15:0] rd_q    [$];
  int done_cnt = 0, valid_cnt = 0, unstable = 0, mstall = 0, rstall = 0;
  logic pv = 1'b0, pwe = 1'b0, prv = 1'b0;
  logic [4:0]  pa;
  logic [15:0] pd, prd;
  logic timeout_hit = 1'b0;

  always @(posedge clk_i) begin
    if (valid_o && !ready_i) wcnt <= wcnt + 1; else wcnt <= 0;
    if (rd_valid_o && !rd_ready_i) rcnt <= rcnt + 1; else rcnt <= 0;
    if (valid_o && ready_i && wr_rd_en_o) mem[addr_o] <= wdata_o;
    if (valid_o && ready_i) begin
      mh_addr.push_back(addr_o);
      mh_data.push_back(wdata_o);
      mh_we.push_back(wr_rd_en_o);
    end
    if (rd_valid_o && rd_ready_i) rd_q.push_back(rd_data_o);
    if (done_o === 1'b1) done_cnt++;
    if (valid_o === 1'b1) valid_cnt++;
    if (valid_o === 1'b1 && ready_i === 1'b0) mstall++;
    if (rd_valid_o === 1'b1 && rd_ready_i === 1'b0) rstall++;
    if (pv && (valid_o !== 1'b1 || addr_o !== pa || wdata_o !== pd || wr_rd_en_o !== pwe))
      unstable++;
    if (prv && (rd_valid_o !== 1'b1 || rd_data_o !== prd)) unstable++;
    if (rst_i !== 1'b1) begin
      pv  = 1'b0;
      prv = 1'b0;
    end else begin
      pv  = (valid_o === 1'b1) && (ready_i === 1'b0);
      pa  = addr_o;
      pd  = wdata_o;
      pwe = wr_rd_en_o;
      prv = (rd_valid_o === 1'b1) && (rd_ready_i === 1'b0);
      prd = rd_data_o;
    end
  end

  task automatic clear_mon();
    mh_addr.delete();
    mh_data.delete();
    mh_we.delete();
    rd_q.delete();
    done_cnt = 0; valid_cnt = 0; unstable = 0; mstall = 0; rstall = 0;
    timeout_hit = 1'b0;
  endtask

  // Offers a command; returns 1 time unit after the accepting edge.
  task automatic send_cmd(input logic wr, input logic [4:0] a, input logic [5:0] len);
    int n = 0;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_addr_i = a; cmd_len_i = len;
    while (cmd_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) timeout_hit = 1'b1;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic feed_word(input logic [15:0] d);
    int n = 0;
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    @(negedge clk_i);
    while (wr_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) timeout_hit = 1'b1;
    @(posedge clk_i);
    #1 wr_valid_i = 1'b0;
  endtask

  // Waits for done_o, then lets the monitor see the closing edge plus one more.
  task automatic wait_done();
    int n = 0;
    @(negedge clk_i);
    while (done_o !== 1'b1 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 400) timeout_hit = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [5:0] len, input logic [15:0] base);
    send_cmd(1'b1, a, len);
    for (int i = 0; i < int'(len); i++) feed_word(base + 16'(i));
    wait_done();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (wr_ready_o !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready_o); end
  endtask

  task automatic test_write_read();
    clear_mon();
    do_write(5'd0, 6'd8, 16'h1000);
    total++; if (mh_addr.size() != 8) begin bad++; $display("FAIL wr_count got=%0d exp=8", mh_addr.size()); end
    for (int i = 0; i < 8 && i < mh_addr.size(); i++) begin
      total++;
      if (mh_addr[i] !== 5'(i) || mh_we[i] !== 1'b1 || mh_data[i] !== 16'h1000 + 16'(i)) begin
        bad++;
        $display("FAIL wr_word%0d got=a%0d we%b d%h exp=a%0d we1 d%h", i, mh_addr[i], mh_we[i],
                 mh_data[i], i, 16'h1000 + 16'(i));
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL wr_done_pulses got=%0d exp=1", done_cnt); end
    clear_mon();
    send_cmd(1'b0, 5'd0, 6'd8);
    @(negedge clk_i);
    total++;
    if (valid_o !== 1'b1 || wr_rd_en_o !== 1'b0 || addr_o !== 5'd0) begin
      bad++;
      $display("FAIL rd_first_req got=v%b we%b a%0d exp=v1 we0 a0", valid_o, wr_rd_en_o, addr_o);
    end
    wait_done();
    total++; if (rd_q.size() != 8) begin bad++; $display("FAIL rd_count got=%0d exp=8", rd_q.size()); end
    for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
      total++;
      if (rd_q[i] !== 16'h1000 + 16'(i)) begin
        bad++; $display("FAIL rd_word%0d got=%h exp=%h", i, rd_q[i], 16'h1000 + 16'(i));
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL rd_done_pulses got=%0d exp=1", done_cnt); end
    total++; if (timeout_hit) begin bad++; $display("FAIL wr_rd_timeout got=1 exp=0"); end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_a [4];
    exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0; exp_a[3] = 5'd1;
    clear_mon();
    do_write(5'd30, 6'd4, 16'hA000);
    total++; if (mh_addr.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", mh_addr.size()); end
    for (int i = 0; i < 4 && i < mh_addr.size(); i++) begin
      total++;
      if (mh_addr[i] !== exp_a[i]) begin
        bad++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, mh_addr[i], exp_a[i]);
      end
    end
    clear_mon();
    send_cmd(1'b0, 5'd30, 6'd4);
    wait_done();
    total++; if (rd_q.size() != 4) begin bad++; $display("FAIL wrap_rd_count got=%0d exp=4", rd_q.size()); end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      total++;
      if (rd_q[i] !== 16'hA000 + 16'(i)) begin
        bad++; $display("FAIL wrap_rd%0d got=%h exp=%h", i, rd_q[i], 16'hA000 + 16'(i));
      end
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    send_cmd(1'b1, 5'd5, 6'd0);
    @(negedge clk_i);
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done_o); end
    @(negedge clk_i);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%b exp=0", done_o); end
    total++; if (valid_cnt != 0) begin bad++; $display("FAIL zero_valid got=%0d exp=0", valid_cnt); end
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL zero_idle got=%b exp=1", cmd_ready_o); end
  endtask

  task automatic test_back_pressure();
    stall_n = 3;
    rd_stall_n = 5;
    clear_mon();
    do_write(5'd8, 6'd8, 16'h2000);
    total++; if (mstall != 24) begin bad++; $display("FAIL bp_wr_stalls got=%0d exp=24", mstall); end
    clear_mon();
    send_cmd(1'b0, 5'd8, 6'd8);
    wait_done();
    total++; if (mstall != 24) begin bad++; $display("FAIL bp_rd_stalls got=%0d exp=24", mstall); end
    total++; if (rstall != 40) begin bad++; $display("FAIL bp_sink_stalls got=%0d exp=40", rstall); end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_stability got=%0d exp=0", unstable); end
    total++; if (rd_q.size() != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", rd_q.size()); end
    for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
      total++;
      if (rd_q[i] !== 16'h2000 + 16'(i)) begin
        bad++; $display("FAIL bp_rd%0d got=%h exp=%h", i, rd_q[i], 16'h2000 + 16'(i));
      end
    end
    total++; if (timeout_hit) begin bad++; $display("FAIL bp_timeout got=1 exp=0"); end
    stall_n = 0;
    rd_stall_n = 0;
  endtask

  task automatic test_reset_mid_burst();
    clear_mon();
    send_cmd(1'b1, 5'd16, 6'd8);
    for (int i = 0; i < 3; i++) feed_word(16'h3000 + 16'(i));
    @(negedge clk_i);  // third request on the memory port
    @(negedge clk_i);  // third handshake done, waiting for word four
    total++; if (mh_addr.size() != 3) begin bad++; $display("FAIL mid_handshakes got=%0d exp=3", mh_addr.size()); end
    rst_i = 1'b0;
    @(negedge clk_i);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", valid_o); end
    total++; if (wr_ready_o !== 1'b0) begin bad++; $display("FAIL mid_wr_ready got=%b exp=0", wr_ready_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", done_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL mid_cmd_ready got=%b exp=1", cmd_ready_o); end
    repeat (3) @(negedge clk_i);
    total++; if (done_cnt != 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy_o); end
  endtask

  initial begin
    rst_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wr_valid_i = 1'b0; wr_data_i = '0;
    test_reset();
    test_write_read();
    test_wrap();
    test_zero_len();
    test_back_pressure();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
